// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM handshake status seen by the memory arbiter.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

endpackage

// File: rtl/mem_arb_pkg.sv
// Memory arbiter types and constants: FSM state encoding, default dcache
// grant limit and the starvation counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DSERV = 2'd1,
      ISERV = 2'd2
   } arb_state_t;

   localparam int unsigned MAX_DGRANTS_DEF = 4;
   localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation counter: counts dcache grants taken while the icache waits.
// sat_o tells the arbiter the icache must be served next.
module arb_starve_cnt
   import mem_arb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             sat_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: clear dominates, increment saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sat_o = (cnt_q >= limit_i);

endmodule

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one RAM port between icache and dcache.
// dcache has priority; the optional starvation guard (macro
// MEM_ARB_STARVE_GUARD_EN) forces an icache grant after MAX_DGRANTS
// consecutive dcache completions while the icache waits.
// Handshake: a cache holds its request until its wait output is low for one
// cycle; that cycle is the completion and its load data is valid only then.
// dbg_state_o exposes the FSM state for observation.
module mem_arbiter
   import cpu_types_pkg::*;
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_DGRANTS = MAX_DGRANTS_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate,
   output arb_state_t  dbg_state_o
);

   if ((MAX_DGRANTS == 0) || (MAX_DGRANTS > 15)) begin : g_bad_limit
      $error("mem_arbiter: MAX_DGRANTS must be in 1..15");
   end

   arb_state_t state_q;
   arb_state_t state_d;
   logic       d_req;
   logic       d_done;
   logic       i_done;
   logic       i_first;

   assign d_req = dREN | dWEN;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic sat;

   arb_starve_cnt u_starve_cnt (
      .clk_i   (CLK),
      .rst_i   (RST),
      .inc_i   (d_done & iREN),
      .clr_i   (i_done | ~iREN),
      .limit_i (CNT_W'(MAX_DGRANTS)),
      .sat_o   (sat)
   );

   assign i_first = iREN & sat;
`else
   assign i_first = 1'b0;
`endif

   // State register; reset abandons any in-flight access.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, RAM strobes/mux and cache responses from state and inputs.
   always_comb begin
      state_d  = state_q;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      d_done   = 1'b0;
      i_done   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (i_first) begin
               state_d = ISERV;
            end else if (d_req) begin
               state_d = DSERV;
            end else if (iREN) begin
               state_d = ISERV;
            end
         end
         DSERV: begin
            if (!d_req) begin
               state_d = IDLE;
            end else begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = ~dWEN;
               if (ramstate == ACCESS) begin
                  dwait   = 1'b0;
                  dload   = ramload;
                  d_done  = 1'b1;
                  state_d = IDLE;
               end else if (ramstate == ERROR) begin
                  state_d = IDLE;
               end
            end
         end
         ISERV: begin
            if (!iREN) begin
               state_d = IDLE;
            end else begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               if (ramstate == ACCESS) begin
                  iwait   = 1'b0;
                  iload   = ramload;
                  i_done  = 1'b1;
                  state_d = IDLE;
               end else if (ramstate == ERROR) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset masks everything so a half-finished access never completes.
      if (RST) begin
         ramREN   = 1'b0;
         ramWEN   = 1'b0;
         ramaddr  = '0;
         ramstore = '0;
         iwait    = 1'b1;
         dwait    = 1'b1;
         iload    = '0;
         dload    = '0;
         d_done   = 1'b0;
         i_done   = 1'b0;
         state_d  = IDLE;
      end
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Honors MEM_ARB_STARVE_GUARD_EN to pick
// the expected grant pattern.
module tb_mem_arbiter;
   import cpu_types_pkg::*;
   import mem_arb_pkg::*;

   localparam int unsigned TB_MAX = 2;

   logic        CLK;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   ramstate_t   ramstate;
   arb_state_t  dbg_state;

   int total;
   int bad;

   logic [31:0] exp_q[$];
   logic [7:0]  gnt_q[$];
   logic [31:0] exp_v;

   mem_arbiter #(.MAX_DGRANTS(TB_MAX)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .iREN        (iREN),
      .iaddr       (iaddr),
      .iwait       (iwait),
      .iload       (iload),
      .dREN        (dREN),
      .dWEN        (dWEN),
      .daddr       (daddr),
      .dstore      (dstore),
      .dwait       (dwait),
      .dload       (dload),
      .ramREN      (ramREN),
      .ramWEN      (ramWEN),
      .ramaddr     (ramaddr),
      .ramstore    (ramstore),
      .ramload     (ramload),
      .ramstate    (ramstate),
      .dbg_state_o (dbg_state)
   );

   // clock / reset
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // driver tasks: inputs change 1 after the rising edge, checks 2 later
   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic go_idle();
      iREN     = 1'b0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      ramstate = FREE;
      ramload  = '0;
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset();
      dREN     = 1'b1;
      daddr    = 32'h10;
      ramstate = ACCESS;
      next_cycle();
      settle();
      total++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin
         bad++;
         $display("FAIL rst_strobes ren=%0b wen=%0b exp=0/0", ramREN, ramWEN);
      end
      total++;
      if (iwait !== 1'b1 || dwait !== 1'b1) begin
         bad++;
         $display("FAIL rst_waits iwait=%0b dwait=%0b exp=1/1", iwait, dwait);
      end
      total++;
      if (iload !== 32'h0 || dload !== 32'h0) begin
         bad++;
         $display("FAIL rst_loads iload=%h dload=%h exp=0/0", iload, dload);
      end
      total++;
      if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         bad++;
         $display("FAIL rst_mux addr=%h store=%h exp=0/0", ramaddr, ramstore);
      end
      next_cycle();
      RST = 1'b0;
      settle();
      total++;
      if (dbg_state !== IDLE || ramREN !== 1'b0 || dwait !== 1'b1) begin
         bad++;
         $display("FAIL rst_after state=%0d ren=%0b dwait=%0b exp=IDLE/0/1",
                  dbg_state, ramREN, dwait);
      end
      go_idle();
   endtask

   task automatic test_iread();
      iREN     = 1'b1;
      iaddr    = 32'h40;
      ramstate = ACCESS;
      ramload  = 32'hDEADBEEF;
      exp_q.push_back(32'hDEADBEEF);
      settle();
      total++;
      if (dbg_state !== IDLE || ramREN !== 1'b0) begin
         bad++;
         $display("FAIL iread_idle state=%0d ren=%0b exp=IDLE/0", dbg_state, ramREN);
      end
      next_cycle();
      settle();
      total++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin
         bad++;
         $display("FAIL iread_strobe ren=%0b wen=%0b addr=%h exp=1/0/40",
                  ramREN, ramWEN, ramaddr);
      end
      total++;
      if (iwait !== 1'b0) begin
         bad++;
         $display("FAIL iread_wait got=%0b exp=0", iwait);
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL iread_data scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (iload !== exp_v) begin
            bad++;
            $display("FAIL iread_data got=%h exp=%h", iload, exp_v);
         end
      end
      next_cycle();
      iREN = 1'b0;
      settle();
      total++;
      if (dbg_state !== IDLE || iwait !== 1'b1 || iload !== 32'h0) begin
         bad++;
         $display("FAIL iread_after state=%0d iwait=%0b iload=%h exp=IDLE/1/0",
                  dbg_state, iwait, iload);
      end
      go_idle();
   endtask

   task automatic test_tie_write();
      iREN     = 1'b1;
      iaddr    = 32'h80;
      dWEN     = 1'b1;
      daddr    = 32'h100;
      dstore   = 32'h12345678;
      ramstate = ACCESS;
      ramload  = 32'h0BADF00D;
      next_cycle();
      settle();
      total++;
      if (dbg_state !== DSERV || ramWEN !== 1'b1 || ramREN !== 1'b0) begin
         bad++;
         $display("FAIL tie_dfirst state=%0d wen=%0b ren=%0b exp=DSERV/1/0",
                  dbg_state, ramWEN, ramREN);
      end
      total++;
      if (ramaddr !== 32'h100 || ramstore !== 32'h12345678) begin
         bad++;
         $display("FAIL tie_dmux addr=%h store=%h exp=100/12345678", ramaddr, ramstore);
      end
      total++;
      if (dwait !== 1'b0 || iwait !== 1'b1) begin
         bad++;
         $display("FAIL tie_dwait dwait=%0b iwait=%0b exp=0/1", dwait, iwait);
      end
      next_cycle();
      dWEN    = 1'b0;
      ramload = 32'hA1B2C3D4;
      exp_q.push_back(32'hA1B2C3D4);
      settle();
      total++;
      if (dbg_state !== IDLE || ramREN !== 1'b0 || ramWEN !== 1'b0) begin
         bad++;
         $display("FAIL tie_turn state=%0d ren=%0b wen=%0b exp=IDLE/0/0",
                  dbg_state, ramREN, ramWEN);
      end
      next_cycle();
      settle();
      total++;
      if (dbg_state !== ISERV || ramaddr !== 32'h80 || iwait !== 1'b0 ||
          ramstore !== 32'h0) begin
         bad++;
         $display("FAIL tie_iserv state=%0d addr=%h iwait=%0b store=%h exp=ISERV/80/0/0",
                  dbg_state, ramaddr, iwait, ramstore);
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL tie_idata scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (iload !== exp_v) begin
            bad++;
            $display("FAIL tie_idata got=%h exp=%h", iload, exp_v);
         end
      end
      go_idle();
   endtask

   task automatic test_busy();
      dREN     = 1'b1;
      daddr    = 32'h200;
      ramstate = BUSY;
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         settle();
         total++;
         if (dwait !== 1'b1 || ramREN !== 1'b1 || ramWEN !== 1'b0 ||
             ramaddr !== 32'h200 || dload !== 32'h0) begin
            bad++;
            $display("FAIL busy_hold%0d dwait=%0b ren=%0b wen=%0b addr=%h dload=%h exp=1/1/0/200/0",
                     i, dwait, ramREN, ramWEN, ramaddr, dload);
         end
         next_cycle();
      end
      ramstate = ACCESS;
      ramload  = 32'hCAFEF00D;
      exp_q.push_back(32'hCAFEF00D);
      settle();
      total++;
      if (dwait !== 1'b0) begin
         bad++;
         $display("FAIL busy_done dwait=%0b exp=0", dwait);
      end
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL busy_data scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (dload !== exp_v) begin
            bad++;
            $display("FAIL busy_data got=%h exp=%h", dload, exp_v);
         end
      end
      go_idle();
   endtask

   task automatic test_grant_order();
      int unsigned cnt;
      int          seen;
      int          budget;
      logic [7:0]  got;
      logic [7:0]  exp_g;
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         if (cnt >= TB_MAX) begin
            gnt_q.push_back("I");
            cnt = 0;
         end else begin
            gnt_q.push_back("D");
            cnt++;
         end
`else
         gnt_q.push_back("D");
`endif
      end
      dREN     = 1'b1;
      daddr    = 32'h600;
      iREN     = 1'b1;
      iaddr    = 32'h700;
      ramstate = ACCESS;
      ramload  = 32'h1111_2222;
      seen     = 0;
      budget   = 0;
      while (seen < 12 && budget < 100) begin
         settle();
         if (dwait === 1'b0 || iwait === 1'b0) begin
            got = (dwait === 1'b0) ? 8'("D") : 8'("I");
            seen++;
            total++;
            if (gnt_q.size() == 0) begin
               bad++;
               $display("FAIL grant_order scoreboard empty at grant %0d", seen);
            end else begin
               exp_g = gnt_q.pop_front();
               if (got !== exp_g || (dwait === 1'b0 && iwait === 1'b0)) begin
                  bad++;
                  $display("FAIL grant_order%0d got=%s exp=%s dwait=%0b iwait=%0b",
                           seen, got, exp_g, dwait, iwait);
               end
            end
         end
         next_cycle();
         budget++;
      end
      total++;
      if (seen != 12) begin
         bad++;
         $display("FAIL grant_budget grants=%0d exp=12", seen);
      end
      gnt_q.delete();
      go_idle();
   endtask

   task automatic test_reset_mid();
      dREN     = 1'b1;
      dWEN     = 1'b1;
      daddr    = 32'h300;
      dstore   = 32'h55AA55AA;
      ramstate = BUSY;
      next_cycle();
      settle();
      total++;
      if (dbg_state !== DSERV || ramWEN !== 1'b1 || ramREN !== 1'b0) begin
         bad++;
         $display("FAIL rmid_wwins state=%0d wen=%0b ren=%0b exp=DSERV/1/0",
                  dbg_state, ramWEN, ramREN);
      end
      next_cycle();
      RST      = 1'b1;
      ramstate = ACCESS;
      settle();
      total++;
      if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0) begin
         bad++;
         $display("FAIL rmid_inrst wen=%0b dwait=%0b addr=%h exp=0/1/0",
                  ramWEN, dwait, ramaddr);
      end
      next_cycle();
      RST = 1'b0;
      settle();
      total++;
      if (dbg_state !== IDLE || ramWEN !== 1'b0 || dwait !== 1'b1) begin
         bad++;
         $display("FAIL rmid_after state=%0d wen=%0b dwait=%0b exp=IDLE/0/1",
                  dbg_state, ramWEN, dwait);
      end
      next_cycle();
      settle();
      total++;
      if (dbg_state !== DSERV || ramWEN !== 1'b1 || dwait !== 1'b0 ||
          ramstore !== 32'h55AA55AA) begin
         bad++;
         $display("FAIL rmid_regrant state=%0d wen=%0b dwait=%0b store=%h exp=DSERV/1/0/55aa55aa",
                  dbg_state, ramWEN, dwait, ramstore);
      end
      go_idle();
   endtask

   task automatic test_error();
      iREN     = 1'b1;
      iaddr    = 32'h44;
      ramstate = ERROR;
      next_cycle();
      settle();
      total++;
      if (dbg_state !== ISERV || iwait !== 1'b1 || ramREN !== 1'b1) begin
         bad++;
         $display("FAIL err_serv state=%0d iwait=%0b ren=%0b exp=ISERV/1/1",
                  dbg_state, iwait, ramREN);
      end
      next_cycle();
      ramstate = ACCESS;
      ramload  = 32'h77778888;
      exp_q.push_back(32'h77778888);
      settle();
      total++;
      if (dbg_state !== IDLE || iwait !== 1'b1 || ramREN !== 1'b0) begin
         bad++;
         $display("FAIL err_idle state=%0d iwait=%0b ren=%0b exp=IDLE/1/0",
                  dbg_state, iwait, ramREN);
      end
      next_cycle();
      settle();
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL err_retry scoreboard empty");
      end else begin
         exp_v = exp_q.pop_front();
         if (iwait !== 1'b0 || iload !== exp_v) begin
            bad++;
            $display("FAIL err_retry iwait=%0b iload=%h exp=0/%h", iwait, iload, exp_v);
         end
      end
      go_idle();
   endtask

   task automatic test_drop();
      dREN     = 1'b1;
      daddr    = 32'h500;
      ramstate = BUSY;
      next_cycle();
      settle();
      total++;
      if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin
         bad++;
         $display("FAIL drop_serv ren=%0b addr=%h exp=1/500", ramREN, ramaddr);
      end
      next_cycle();
      dREN     = 1'b0;
      ramstate = ACCESS;
      settle();
      total++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin
         bad++;
         $display("FAIL drop_now ren=%0b wen=%0b dwait=%0b exp=0/0/1",
                  ramREN, ramWEN, dwait);
      end
      next_cycle();
      settle();
      total++;
      if (dbg_state !== IDLE) begin
         bad++;
         $display("FAIL drop_idle state=%0d exp=IDLE", dbg_state);
      end
      go_idle();
   endtask

   // sequencer and final report
   initial begin
      total    = 0;
      bad      = 0;
      RST      = 1'b1;
      iREN     = 1'b0;
      iaddr    = '0;
      dREN     = 1'b0;
      dWEN     = 1'b0;
      daddr    = '0;
      dstore   = '0;
      ramload  = '0;
      ramstate = FREE;

      test_reset();
      test_iread();
      test_tie_write();
      test_busy();
      test_grant_order();
      test_reset_mid();
      test_error();
      test_drop();

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover entries=%0d exp=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
